// File: rtl/beta_layer_ram_pkg.sv
// Shared constants and helpers for the layered beta RAM.
// Beat counts and per-layer slot offsets are computed here so that the
// port controllers and the storage agree on the same vector geometry.
package beta_ram_pkg;

   // Deepest layer for the default code length (N = 1024).
   localparam int LMAX    = 8;
   localparam int LAYER_W = 5;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } port_state_t;

   // Deepest layer for an arbitrary code length.
   function automatic int lmax_of(input int n);
      return $clog2(n) - 2;
   endfunction

   // Write beats per vector: each beat carries 2*P values (two halves).
   function automatic int bw(input int l, input int p);
      int v;
      v = (1 << l) / (2 * p);
      return (v < 1) ? 1 : v;
   endfunction

   // Read beats per vector: each beat returns P values.
   function automatic int br(input int l, input int p);
      int v;
      v = (1 << l) / p;
      return (v < 1) ? 1 : v;
   endfunction

   // Base entry of a slot inside the storage array of layer l.
   function automatic int store_offset(input int l, input int slot);
      return slot << l;
   endfunction

endpackage

// File: rtl/beta_layer_ram_if.sv
// Handshake/data bundle of the layered beta RAM.
// master drives strobes, layer/slot selects and write data; slave returns
// read data and status.
interface beta_layer_ram_if
   import beta_ram_pkg::*;
#(
   parameter int P     = 32,
   parameter int Q     = 6,
   parameter int DEPTH = 2
);
   localparam int SW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic               w_en;
   logic [LAYER_W-1:0] w_layer;
   logic [SW-1:0]      w_slot;
   logic [2*P*Q-1:0]   b_in;
   logic               r_en;
   logic [LAYER_W-1:0] r_layer;
   logic [SW-1:0]      r_slot;
   logic [P*Q-1:0]     b_out;
   logic               r_valid;
   logic               r_last;
   logic               w_last;
   logic               err;

   modport master (
      output w_en, w_layer, w_slot, b_in, r_en, r_layer, r_slot,
      input  b_out, r_valid, r_last, w_last, err
   );

   modport slave (
      input  w_en, w_layer, w_slot, b_in, r_en, r_layer, r_slot,
      output b_out, r_valid, r_last, w_last, err
   );

endinterface

// File: rtl/beta_layer_ram_port_ctrl.sv
// Per-port vector sequencer: tracks the beat within a multi-beat vector,
// latches layer/slot at beat 0 and flags illegal layers.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no vector open; next strobe is beat 0, layer/slot from inputs
// BUSY    | vector open; strobes advance beat_q, latched layer/slot used
module beta_port_ctrl
   import beta_ram_pkg::*;
#(
   parameter int P        = 32,
   parameter int N        = 1024,
   parameter int SW       = 1,
   parameter int CW       = 11,
   parameter bit IS_WRITE = 1'b0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [LAYER_W-1:0] layer,
   input  logic [SW-1:0]      slot,
   output logic [LAYER_W-1:0] cur_layer,
   output logic [SW-1:0]      cur_slot,
   output logic [CW-1:0]      cur_beat,
   output logic               last,
   output logic               bad
);
   localparam int LM = lmax_of(N);

   port_state_t        state_q, state_d;
   logic [CW-1:0]      beat_q, beat_d;
   logic [LAYER_W-1:0] layer_q;
   logic [SW-1:0]      slot_q;
   logic [CW-1:0]      nbeats;

   // State, beat counter and beat-0 latch of layer/slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         beat_q  <= '0;
         layer_q <= '0;
         slot_q  <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         if (en && (state_q == ST_IDLE)) begin
            layer_q <= layer;
            slot_q  <= slot;
         end
      end
   end

   // Effective selects for this cycle, vector length and next state.
   always_comb begin
      cur_layer = layer;
      cur_slot  = slot;
      cur_beat  = '0;
      if (state_q == ST_BUSY) begin
         cur_layer = layer_q;
         cur_slot  = slot_q;
         cur_beat  = beat_q;
      end
      // Illegal layers collapse to a single beat; they never reach BUSY.
      bad = (cur_layer == '0) || (int'(cur_layer) > LM);
      if (bad)
         nbeats = CW'(1);
      else if (IS_WRITE)
         nbeats = CW'(bw(int'(cur_layer), P));
      else
         nbeats = CW'(br(int'(cur_layer), P));
      last    = (cur_beat == (nbeats - CW'(1)));
      state_d = state_q;
      beat_d  = beat_q;
      if (en) begin
         if (last) begin
            state_d = ST_IDLE;
            beat_d  = '0;
         end else begin
            state_d = ST_BUSY;
            beat_d  = cur_beat + CW'(1);
         end
      end
   end

endmodule

// File: rtl/beta_layer_ram.sv
// Layered beta-value RAM: one storage array per layer (2^l values per slot),
// written two half-vectors per beat and read P values per beat with one
// cycle of latency.
// Optional feature macro: BETA_RAM_BYPASS_EN -- same-cycle read of lanes
// being written returns the incoming b_in data instead of the stored data.
module beta_layer_ram
   import beta_ram_pkg::*;
#(
   parameter int P     = 32,
   parameter int Q     = 6,
   parameter int N     = 1024,
   parameter int DEPTH = 2
) (
   input logic              clk,
   input logic              rst,
   beta_layer_ram_if.slave  bus
);
   localparam int LM = lmax_of(N);
   localparam int SW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(N) + 1;

   logic [LAYER_W-1:0] w_layer, r_layer;
   logic [SW-1:0]      w_slot, r_slot;
   logic [CW-1:0]      w_beat, r_beat;
   logic               w_last_beat, r_last_beat;
   logic               w_bad, r_bad;
   logic               w_commit;
   logic [P*Q-1:0]     rd_or [0:LM];
   logic [P*Q-1:0]     b_out_q;
   logic               r_valid_q, r_last_q, err_q;

   beta_port_ctrl #(
      .P(P), .N(N), .SW(SW), .CW(CW), .IS_WRITE(1'b1)
   ) u_wr_ctrl (
      .clk       (clk),
      .rst       (rst),
      .en        (bus.w_en),
      .layer     (bus.w_layer),
      .slot      (bus.w_slot),
      .cur_layer (w_layer),
      .cur_slot  (w_slot),
      .cur_beat  (w_beat),
      .last      (w_last_beat),
      .bad       (w_bad)
   );

   beta_port_ctrl #(
      .P(P), .N(N), .SW(SW), .CW(CW), .IS_WRITE(1'b0)
   ) u_rd_ctrl (
      .clk       (clk),
      .rst       (rst),
      .en        (bus.r_en),
      .layer     (bus.r_layer),
      .slot      (bus.r_slot),
      .cur_layer (r_layer),
      .cur_slot  (r_slot),
      .cur_beat  (r_beat),
      .last      (r_last_beat),
      .bad       (r_bad)
   );

   assign w_commit = bus.w_en && !w_bad;
   assign rd_or[0] = '0;

   // Each layer returns zero unless selected, so the per-layer read words
   // are simply OR-reduced along the chain.
   for (genvar g = 1; g <= LM; g++) begin : g_layer
      localparam int LEN  = 1 << g;
      localparam int HALF = LEN / 2;
      localparam int M    = (P < HALF) ? P : HALF;
      localparam int RM   = (P < LEN) ? P : LEN;
      localparam int ENT  = LEN * DEPTH;
      localparam int AW   = (ENT > 1) ? $clog2(ENT) : 1;

      logic [Q-1:0]   mem [0:ENT-1];
      logic [P*Q-1:0] rd_data;
      logic           hit_w;
      int             w_base;
      int             r_base;

      assign hit_w  = w_commit && (w_layer == LAYER_W'(g));
      assign w_base = store_offset(g, int'(w_slot)) + int'(w_beat) * P;
      assign r_base = store_offset(g, int'(r_slot)) + int'(r_beat) * P;

      // Store the left half at the front and the right half at 2^(l-1).
      always_ff @(posedge clk) begin
         if (rst) begin
            for (int e = 0; e < ENT; e++) mem[e] <= '0;
         end else if (hit_w) begin
            for (int i = 0; i < M; i++) begin
               mem[AW'(w_base + i)]        <= bus.b_in[i*Q +: Q];
               mem[AW'(w_base + HALF + i)] <= bus.b_in[(P+i)*Q +: Q];
            end
         end
      end

      // Read word for this layer; lanes past the vector length stay zero.
      always_comb begin
`ifdef BETA_RAM_BYPASS_EN
         int p;
         int wlo;
         p   = 0;
         wlo = int'(w_beat) * P;
`endif
         rd_data = '0;
         if (r_layer == LAYER_W'(g)) begin
            for (int i = 0; i < RM; i++) begin
               rd_data[i*Q +: Q] = mem[AW'(r_base + i)];
`ifdef BETA_RAM_BYPASS_EN
               if (hit_w && (w_slot == r_slot)) begin
                  p = int'(r_beat) * P + i;
                  if ((p >= wlo) && (p < wlo + M))
                     rd_data[i*Q +: Q] = bus.b_in[(p - wlo)*Q +: Q];
                  else if ((p >= HALF + wlo) && (p < HALF + wlo + M))
                     rd_data[i*Q +: Q] = bus.b_in[(P + p - HALF - wlo)*Q +: Q];
               end
`endif
            end
         end
      end

      assign rd_or[g] = rd_or[g-1] | rd_data;
   end

   // Read pipeline register and sticky illegal-layer flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         b_out_q   <= '0;
         r_valid_q <= 1'b0;
         r_last_q  <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         r_valid_q <= bus.r_en;
         r_last_q  <= bus.r_en && r_last_beat;
         b_out_q   <= (bus.r_en && !r_bad) ? rd_or[LM] : '0;
         if ((bus.w_en && w_bad) || (bus.r_en && r_bad))
            err_q <= 1'b1;
      end
   end

   assign bus.b_out   = b_out_q;
   assign bus.r_valid = r_valid_q;
   assign bus.r_last  = r_last_q;
   assign bus.w_last  = bus.w_en && w_last_beat;
   assign bus.err     = err_q;

endmodule

// File: tb/tb_beta_layer_ram.sv
// Self-checking bench for beta_layer_ram: directed corner sequences, a
// table of vector operations and randomized traffic against a vector-level
// model of the stored layers.
module tb_beta_layer_ram;
   localparam int P = 32, Q = 6, N = 1024, DEPTH = 2, LMX = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   beta_layer_ram_if #(.P(P), .Q(Q), .DEPTH(DEPTH)) bus ();
   beta_layer_ram #(.P(P), .Q(Q), .N(N), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      bit is_wr;
      int layer;
      int slot;
      int beats;
      bit err_after;
   } vec_t;

   int checks = 0;
   int errors = 0;
   logic [Q-1:0]   model [0:LMX][0:DEPTH-1][0:255];
   logic [Q-1:0]   wbuf  [0:255];
   logic           err_model;
   logic           exp_rv, exp_rl;
   logic [P*Q-1:0] exp_bo, old_v;
   vec_t           tbl [15];

   task automatic check(input string name, input logic [P*Q-1:0] act, input logic [P*Q-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic bit legal(input int l);
      return (l >= 1) && (l <= LMX);
   endfunction

   function automatic int nbw(input int l);
      int v;
      if (!legal(l)) return 1;
      v = (1 << l) / (2 * P);
      return (v < 1) ? 1 : v;
   endfunction

   function automatic int nbr(input int l);
      int v;
      if (!legal(l)) return 1;
      v = (1 << l) / P;
      return (v < 1) ? 1 : v;
   endfunction

   function automatic logic [P*Q-1:0] exp_read(input int l, input int s, input int k);
      logic [P*Q-1:0] v;
      v = '0;
      if (legal(l))
         for (int i = 0; i < P; i++)
            if (k * P + i < (1 << l)) v[i*Q +: Q] = model[l][s][k*P+i];
      return v;
   endfunction

   // Lanes outside the half-vector width carry garbage that must be ignored.
   function automatic logic [2*P*Q-1:0] build_bin(input int l, input int k);
      logic [2*P*Q-1:0] v;
      int half, m;
      half = (1 << l) / 2;
      m    = (P < half) ? P : half;
      for (int i = 0; i < 2 * P; i++) v[i*Q +: Q] = Q'($urandom);
      if (legal(l))
         for (int i = 0; i < m; i++) begin
            v[i*Q +: Q]     = wbuf[k*P+i];
            v[(P+i)*Q +: Q] = wbuf[half+k*P+i];
         end
      return v;
   endfunction

   task automatic fill_rand();
      for (int i = 0; i < 256; i++) wbuf[i] = Q'($urandom);
   endtask

   task automatic clear_model();
      for (int l = 0; l <= LMX; l++)
         for (int s = 0; s < DEPTH; s++)
            for (int p = 0; p < 256; p++) model[l][s][p] = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      check("r_valid", bus.r_valid, exp_rv);
      check("r_last", bus.r_last, exp_rl);
      check("b_out", bus.b_out, exp_bo);
      check("err", bus.err, err_model);
      exp_rv   = 1'b0;
      exp_rl   = 1'b0;
      exp_bo   = '0;
      bus.r_en = 1'b0;
      bus.w_en = 1'b0;
   endtask

   task automatic gap_ticks(input bit gaps);
      if (gaps) repeat ($urandom_range(0, 2)) tick();
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      exp_rv    = 1'b0;
      exp_rl    = 1'b0;
      exp_bo    = '0;
      err_model = 1'b0;
      clear_model();
      tick();
      rst = 1'b0;
   endtask

   // Mid-vector beats present a different layer and slot, which must be ignored.
   task automatic do_write(input int l, input int s, input int nb, input bit gaps);
      for (int k = 0; k < nb; k++) begin
         bus.w_en    = 1'b1;
         bus.w_layer = (k == 0) ? 5'(l) : 5'((l % 8) + 1);
         bus.w_slot  = (k == 0) ? 1'(s) : ~1'(s);
         bus.b_in    = build_bin(l, k);
         if (k == 0 && !legal(l)) err_model = 1'b1;
         #1;
         check("w_last", bus.w_last, (k == nb - 1));
         tick();
         if (k < nb - 1) gap_ticks(gaps);
      end
      if (legal(l))
         for (int p = 0; p < (1 << l); p++) model[l][s][p] = wbuf[p];
   endtask

   task automatic read_beat(input int l, input int s, input int k, input int nb);
      bus.r_en    = 1'b1;
      bus.r_layer = (k == 0) ? 5'(l) : 5'((l % 8) + 1);
      bus.r_slot  = (k == 0) ? 1'(s) : ~1'(s);
      exp_rv      = 1'b1;
      exp_rl      = (k == nb - 1);
      exp_bo      = exp_read(l, s, k);
      if (k == 0 && !legal(l)) err_model = 1'b1;
   endtask

   task automatic do_read(input int l, input int s, input int nb, input bit gaps);
      for (int k = 0; k < nb; k++) begin
         read_beat(l, s, k, nb);
         tick();
         if (k < nb - 1) gap_ticks(gaps);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst         = 1'b1;
      bus.w_en    = 1'b0;
      bus.r_en    = 1'b0;
      bus.w_layer = '0;
      bus.w_slot  = '0;
      bus.r_layer = '0;
      bus.r_slot  = '0;
      bus.b_in    = '0;
      exp_rv      = 1'b0;
      exp_rl      = 1'b0;
      exp_bo      = '0;
      err_model   = 1'b0;
      clear_model();
      tick();
      check("w_last_rst", bus.w_last, 1'b0);
      rst = 1'b0;

      // Layer 8 slot 1: index data, 4 write beats, 8 back-to-back read beats.
      for (int i = 0; i < 256; i++) wbuf[i] = Q'(i);
      do_write(8, 1, 4, 1'b0);
      do_read(8, 1, 8, 1'b0);

      // Layer 1: left lane0 = 5, right lane0 = 9.
      fill_rand();
      wbuf[0] = 6'd5;
      wbuf[1] = 6'd9;
      do_write(1, 0, 1, 1'b0);
      bus.r_en    = 1'b1;
      bus.r_layer = 5'd1;
      bus.r_slot  = 1'b0;
      exp_rv      = 1'b1;
      exp_rl      = 1'b1;
      exp_bo      = '0;
      exp_bo[5:0] = 6'd5;
      exp_bo[11:6] = 6'd9;
      tick();

      // Layer 7 with idle gaps and a changing w_layer mid-vector.
      fill_rand();
      do_write(7, 1, 2, 1'b0);
      fill_rand();
      do_write(7, 0, 2, 1'b1);
      do_read(7, 0, 4, 1'b1);
      do_read(7, 1, 4, 1'b0);
      do_read(8, 1, 8, 1'b1);

      // Same-cycle read and write of layer 6 slot 0 beat 0.
      fill_rand();
      do_write(6, 0, 1, 1'b0);
      old_v = exp_read(6, 0, 0);
      fill_rand();
      bus.w_en    = 1'b1;
      bus.w_layer = 5'd6;
      bus.w_slot  = 1'b0;
      bus.b_in    = build_bin(6, 0);
      bus.r_en    = 1'b1;
      bus.r_layer = 5'd6;
      bus.r_slot  = 1'b0;
      for (int p = 0; p < 64; p++) model[6][0][p] = wbuf[p];
      exp_rv = 1'b1;
      exp_rl = 1'b0;
`ifdef BETA_RAM_BYPASS_EN
      exp_bo = exp_read(6, 0, 0);
`else
      exp_bo = old_v;
`endif
      tick();
      read_beat(6, 0, 1, 2);
      tick();
      do_read(6, 0, 2, 1'b0);

      // Reset during read beat 3 of layer 8 aborts the vector.
      for (int k = 0; k < 3; k++) begin
         read_beat(8, 1, k, 8);
         tick();
      end
      bus.r_en    = 1'b1;
      bus.r_layer = 5'd3;
      do_reset();
      do_read(8, 1, 8, 1'b0);

      // Table of vector operations with fixed beat counts and err status.
      tbl[0]  = '{1'b1, 1, 0, 1, 1'b0};
      tbl[1]  = '{1'b1, 5, 1, 1, 1'b0};
      tbl[2]  = '{1'b1, 6, 0, 1, 1'b0};
      tbl[3]  = '{1'b1, 7, 1, 2, 1'b0};
      tbl[4]  = '{1'b1, 8, 0, 4, 1'b0};
      tbl[5]  = '{1'b0, 1, 0, 1, 1'b0};
      tbl[6]  = '{1'b0, 4, 1, 1, 1'b0};
      tbl[7]  = '{1'b0, 5, 1, 1, 1'b0};
      tbl[8]  = '{1'b0, 6, 0, 2, 1'b0};
      tbl[9]  = '{1'b0, 7, 1, 4, 1'b0};
      tbl[10] = '{1'b0, 8, 0, 8, 1'b0};
      tbl[11] = '{1'b0, 3, 0, 1, 1'b0};
      tbl[12] = '{1'b1, 0, 0, 1, 1'b1};
      tbl[13] = '{1'b0, 9, 1, 1, 1'b1};
      tbl[14] = '{1'b0, 2, 1, 1, 1'b1};
      do_reset();
      for (int t = 0; t < 15; t++) begin
         fill_rand();
         if (tbl[t].is_wr) do_write(tbl[t].layer, tbl[t].slot, tbl[t].beats, 1'b0);
         else              do_read(tbl[t].layer, tbl[t].slot, tbl[t].beats, 1'b0);
         check("tbl_err", bus.err, tbl[t].err_after);
      end

      // Randomized traffic; legal layers dominate, illegal ones latch err.
      do_reset();
      for (int n = 0; n < 60; n++) begin
         int l, s;
         l = ($urandom_range(0, 9) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : 9 + $urandom_range(0, 22))
                                         : $urandom_range(1, LMX);
         s = $urandom_range(0, DEPTH - 1);
         fill_rand();
         if ($urandom_range(0, 1) == 0) do_write(l, s, nbw(l), 1'(($urandom)));
         else                           do_read(l, s, nbr(l), 1'(($urandom)));
      end

      do_reset();
      check("err_cleared", bus.err, 1'b0);
      do_read(8, 0, 8, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
